// File: rtl/matmul_calc.sv
// matmul_calc: signed matrix-multiply core on an output-stationary
// MAX_DIM x MAX_DIM systolic MAC grid with sticky per-element overflow flags.
module matmul_calc #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [$clog2(MAX_DIM)-1:0]             n_dim_i,
    input  logic [$clog2(MAX_DIM)-1:0]             k_dim_i,
    input  logic [$clog2(MAX_DIM)-1:0]             m_dim_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  a_mat_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  b_mat_i,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   c_mat_o,
    output logic [MAX_DIM*MAX_DIM-1:0]             ovf_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    localparam int CNT_W = $clog2(3 * MAX_DIM);
    localparam int LAST  = 3 * MAX_DIM - 1;

    typedef logic signed [DATA_WIDTH-1:0]   op_t;
    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    typedef logic signed [BUS_WIDTH-1:0]    acc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic                         w_accept;
    logic [CNT_W-1:0]             r_cnt;

    op_t   r_am  [MAX_DIM][MAX_DIM];
    op_t   r_bm  [MAX_DIM][MAX_DIM];
    op_t   r_ask [MAX_DIM][MAX_DIM];
    op_t   r_bsk [MAX_DIM][MAX_DIM];
    acc_t  r_acc [MAX_DIM][MAX_DIM];
    logic [MAX_DIM*MAX_DIM-1:0]   r_ovf;

    op_t   w_a_in [MAX_DIM][MAX_DIM];
    op_t   w_b_in [MAX_DIM][MAX_DIM];
    prod_t w_prod [MAX_DIM][MAX_DIM];
    acc_t  w_ext  [MAX_DIM][MAX_DIM];
    acc_t  w_sum  [MAX_DIM][MAX_DIM];
    logic [MAX_DIM*MAX_DIM-1:0]   w_ovf;

    assign w_accept = (r_state == S_IDLE) && start_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: fixed-length CALC, single-cycle DONE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start_i) w_next = S_CALC;
            S_CALC: if (r_cnt == CNT_W'(LAST)) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Injection-step counter, restarted on every accepted start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Skewed edge injection plus neighbour forwarding into each PE
    always_comb begin
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
                w_a_in[i][j] = '0;
                w_b_in[i][j] = '0;
            end
        end
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int k = 0; k < MAX_DIM; k++) begin
                if (int'(r_cnt) == i + k) w_a_in[i][0] = r_am[i][k];
                if (int'(r_cnt) == i + k) w_b_in[0][i] = r_bm[k][i];
            end
        end
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 1; j < MAX_DIM; j++) begin
                w_a_in[i][j] = r_ask[i][j-1];
                w_b_in[j][i] = r_bsk[j-1][i];
            end
        end
    end

    // Per-PE multiply, wrapping accumulate and signed-overflow detect
    always_comb begin
        w_ovf = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
                w_prod[i][j] = prod_t'(w_a_in[i][j]) * prod_t'(w_b_in[i][j]);
                w_ext[i][j]  = acc_t'(w_prod[i][j]);
                w_sum[i][j]  = r_acc[i][j] + w_ext[i][j];
                w_ovf[i*MAX_DIM+j] =
                    (r_acc[i][j][BUS_WIDTH-1] == w_ext[i][j][BUS_WIDTH-1]) &&
                    (w_sum[i][j][BUS_WIDTH-1] != r_acc[i][j][BUS_WIDTH-1]);
            end
        end
    end

    // Operand latch with dimension masking, skew pipeline and accumulators
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    r_am[i][j]  <= '0;
                    r_bm[i][j]  <= '0;
                    r_ask[i][j] <= '0;
                    r_bsk[i][j] <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            r_ovf <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    r_am[i][j] <= (i <= int'(n_dim_i) && j <= int'(k_dim_i)) ?
                        a_mat_i[(i*MAX_DIM+j)*DATA_WIDTH +: DATA_WIDTH] : '0;
                    r_bm[i][j] <= (i <= int'(k_dim_i) && j <= int'(m_dim_i)) ?
                        b_mat_i[(i*MAX_DIM+j)*DATA_WIDTH +: DATA_WIDTH] : '0;
                    r_ask[i][j] <= '0;
                    r_bsk[i][j] <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (r_state == S_CALC) begin
            r_ovf <= r_ovf | w_ovf;
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    r_ask[i][j] <= w_a_in[i][j];
                    r_bsk[i][j] <= w_b_in[i][j];
                    r_acc[i][j] <= w_sum[i][j];
                end
            end
        end
    end

    // Results come straight from the accumulators and sticky flags
    always_comb begin
        c_mat_o = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
                c_mat_o[(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH] = r_acc[i][j];
            end
        end
    end

    assign ovf_o  = r_ovf;
    assign busy_o = (r_state != S_IDLE);
    assign done_o = (r_state == S_DONE);

endmodule
